// File: rtl/acc_tx_pkg.sv
// Shared definitions for the accumulator-to-UART streamer: state encoding,
// default UART byte width and byte-count helpers.
package acc_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SEND = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_CHK  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam int DBIT_DEF = 8;

    function automatic int nbytes(input int data_w, input int dbit);
        return (data_w + dbit - 1) / dbit;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/acc_uart_streamer_rise_det.sv
// Rising-edge detector for the trigger level; history flop clears on reset so
// a level already high at reset release reads as one edge.
module rise_det (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/acc_uart_streamer.sv
// Captures a result word on the trigger edge and streams it as NBYTES bytes
// through the uart_tx start/done handshake. Define ACC_TX_CHKSUM_EN to append an XOR checksum byte.
module acc_uart_streamer
    import acc_tx_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DBIT      = DBIT_DEF,
    parameter int MSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_trigger,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_tx_done,
    output logic              o_tx_start,
    output logic [DBIT-1:0]   o_tx_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    localparam int NBYTES = nbytes(DATA_W, DBIT);
    localparam int IDX_W  = idx_w(NBYTES);
    localparam int PAD_W  = NBYTES * DBIT;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_shadow;
    logic                r_overrun;
    logic                w_rise;
    logic                w_last;
    logic [IDX_W-1:0]    w_sel;
    logic [PAD_W-1:0]    w_pad;
    logic [PAD_W-1:0]    w_shift;
    logic [DBIT-1:0]     w_byte;
    logic [DBIT-1:0]     w_tx;
    logic                w_start;

    rise_det u_rise (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_trigger),
        .o_rise  (w_rise)
    );

    // Zero-extend to whole bytes so the top byte pads with 0 above DATA_W.
    assign w_pad   = PAD_W'(r_shadow);
    assign w_sel   = (MSB_FIRST != 0) ? (IDX_W'(NBYTES - 1) - r_idx) : r_idx;
    assign w_shift = w_pad >> (int'(w_sel) * DBIT);
    assign w_byte  = w_shift[DBIT-1:0];
    assign w_last  = (r_idx == IDX_W'(NBYTES - 1));

`ifdef ACC_TX_CHKSUM_EN
    logic [DBIT-1:0] r_sum;
    logic            r_chk;

    assign w_tx    = (r_chk || r_state == ST_CHK) ? r_sum : w_byte;
    assign w_start = (r_state == ST_SEND) || (r_state == ST_CHK);
`else
    assign w_tx    = w_byte;
    assign w_start = (r_state == ST_SEND);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_overrun <= 1'b0;
`ifdef ACC_TX_CHKSUM_EN
            r_sum     <= '0;
            r_chk     <= 1'b0;
`endif
        end else begin
            if (w_rise && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_shadow <= i_data;
                        r_idx    <= '0;
                        r_state  <= ST_SEND;
`ifdef ACC_TX_CHKSUM_EN
                        r_sum    <= '0;
                        r_chk    <= 1'b0;
`endif
                    end
                end
                ST_SEND: begin
`ifdef ACC_TX_CHKSUM_EN
                    r_sum <= r_sum ^ w_byte;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
`ifdef ACC_TX_CHKSUM_EN
                        if (r_chk) begin
                            r_state <= ST_DONE;
                        end else if (w_last) begin
                            r_state <= ST_CHK;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_SEND;
                        end
`else
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_SEND;
                        end
`endif
                    end
                end
`ifdef ACC_TX_CHKSUM_EN
                ST_CHK: begin
                    r_chk   <= 1'b1;
                    r_state <= ST_WAIT;
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_start = w_start;
    assign o_tx_data  = (r_state == ST_IDLE) ? '0 : w_tx;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_acc_uart_streamer.sv
// Scoreboard bench for acc_uart_streamer: three parameterisations share one
// behavioural uart_tx responder that checks each started byte and holds it.
module tb_acc_uart_streamer;

    localparam int UART_CYC = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_done = 1'b0;

    logic        trig0 = 1'b0, trig1 = 1'b0, trig2 = 1'b0;
    logic [15:0] data0 = '0;
    logic [11:0] data1 = '0;
    logic [23:0] data2 = '0;

    logic        start0, start1, start2;
    logic [7:0]  txd0, txd1, txd2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        ovr0, ovr1, ovr2;

    int          n_total = 0;
    int          n_bad = 0;
    int          n_starts = 0;
    int          n_done [3] = '{0, 0, 0};
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    acc_uart_streamer #(.DATA_W(16), .DBIT(8), .MSB_FIRST(0)) u_d16 (
        .i_clk(clk), .i_reset(rst_n), .i_trigger(trig0), .i_data(data0),
        .i_tx_done(tx_done), .o_tx_start(start0), .o_tx_data(txd0),
        .o_busy(busy0), .o_done(done0), .o_overrun(ovr0)
    );

    acc_uart_streamer #(.DATA_W(12), .DBIT(8), .MSB_FIRST(1)) u_d12 (
        .i_clk(clk), .i_reset(rst_n), .i_trigger(trig1), .i_data(data1),
        .i_tx_done(tx_done), .o_tx_start(start1), .o_tx_data(txd1),
        .o_busy(busy1), .o_done(done1), .o_overrun(ovr1)
    );

    acc_uart_streamer #(.DATA_W(24), .DBIT(8), .MSB_FIRST(0)) u_d24 (
        .i_clk(clk), .i_reset(rst_n), .i_trigger(trig2), .i_data(data2),
        .i_tx_done(tx_done), .o_tx_start(start2), .o_tx_data(txd2),
        .o_busy(busy2), .o_done(done2), .o_overrun(ovr2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic exp2(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
`ifdef ACC_TX_CHKSUM_EN
        exp_q.push_back(b0 ^ b1);
`endif
    endtask

    task automatic exp3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
`ifdef ACC_TX_CHKSUM_EN
        exp_q.push_back(b0 ^ b1 ^ b2);
`endif
    endtask

    function automatic logic [7:0] txd_of(input int s);
        case (s)
            0:       return txd0;
            1:       return txd1;
            default: return txd2;
        endcase
    endfunction

    // Behavioural uart_tx: takes a byte on start, returns a done tick UART_CYC cycles later.
    int         u_cnt = 0;
    bit         u_busy = 1'b0;
    int         u_src = 0;
    logic [7:0] u_byte = '0;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst_n) begin
            u_busy = 1'b0;
        end else if (u_busy) begin
            if ({start2, start1, start0} != 3'b000)
                check("start_overlap", {start2, start1, start0}, 3'b000);
            if (u_cnt == 0) begin
                check("tx_data_hold", txd_of(u_src), u_byte);
                tx_done = 1'b1;
                u_busy  = 1'b0;
            end else begin
                u_cnt--;
            end
        end else if ({start2, start1, start0} != 3'b000) begin
            u_src  = start0 ? 0 : (start1 ? 1 : 2);
            u_byte = txd_of(u_src);
            n_starts++;
            if (exp_q.size() == 0)
                check("extra_start", {start2, start1, start0}, 3'b000);
            else
                check("byte", u_byte, exp_q.pop_front());
            u_busy = 1'b1;
            u_cnt  = UART_CYC;
        end
    end

    always @(negedge clk) begin
        if (done0) n_done[0]++;
        if (done1) n_done[1]++;
        if (done2) n_done[2]++;
    end

    task automatic wait_done(input int d, input int base, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done[d] > base) break;
        end
        if (i == budget) check("timeout_done", n_done[d], base + 1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_starts >= target) break;
        end
        if (i == budget) check("timeout_start", n_starts, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int s0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_d16", {start0, txd0, busy0, done0, ovr0}, '0);
        check("rst_d12", {start1, txd1, busy1, done1, ovr1}, '0);
        check("rst_d24", {start2, txd2, busy2, done2, ovr2}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: LSB-first 16-bit word
        exp2(8'hEF, 8'hBE);
        data0 = 16'hBEEF;
        base  = n_done[0];
        trig0 = 1'b1;
        @(negedge clk);
        check("t1_first_start", start0, 1'b1);
        check("t1_busy_high", busy0, 1'b1);
        wait_done(0, base, 200);
        repeat (5) @(negedge clk);
        check("t1_done_once", n_done[0] - base, 1);
        check("t1_busy_low", busy0, 1'b0);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_no_overrun", ovr0, 1'b0);
        trig0 = 1'b0;
        @(negedge clk);

        // 2: MSB-first 12-bit word, top byte padded
        exp2(8'h0A, 8'hBC);
        data1 = 12'hABC;
        base  = n_done[1];
        trig1 = 1'b1;
        wait_done(1, base, 200);
        repeat (3) @(negedge clk);
        check("t2_done_once", n_done[1] - base, 1);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_busy_low", busy1, 1'b0);
        trig1 = 1'b0;
        @(negedge clk);

        // 3: level held high gives one frame; re-arm gives another
        exp2(8'hA5, 8'h5A);
        data0 = 16'h5AA5;
        base  = n_done[0];
        trig0 = 1'b1;
        repeat (120) @(negedge clk);
        check("t3_one_frame", n_done[0] - base, 1);
        check("t3_queue_empty", exp_q.size(), 0);
        trig0 = 1'b0;
        @(negedge clk);
        exp2(8'h02, 8'h01);
        data0 = 16'h0102;
        base  = n_done[0];
        trig0 = 1'b1;
        wait_done(0, base, 200);
        repeat (3) @(negedge clk);
        check("t3_second_frame", n_done[0] - base, 1);
        check("t3_queue_empty2", exp_q.size(), 0);
        trig0 = 1'b0;
        @(negedge clk);

        // 4: trigger edge during byte 0 must not disturb the frame
        exp2(8'hD4, 8'hC3);
        data0 = 16'hC3D4;
        base  = n_done[0];
        trig0 = 1'b1;
        @(negedge clk);
        check("t4_started", start0, 1'b1);
        trig0 = 1'b0;
        @(negedge clk);
        data0 = 16'h1234;
        trig0 = 1'b1;
        @(negedge clk);
        check("t4_overrun_set", ovr0, 1'b1);
        wait_done(0, base, 200);
        repeat (3) @(negedge clk);
        check("t4_done_once", n_done[0] - base, 1);
        check("t4_queue_empty", exp_q.size(), 0);
        check("t4_overrun_sticky", ovr0, 1'b1);
        trig0 = 1'b0;
        @(negedge clk);

        // 5: reset during WAIT of byte 1 abandons the frame
        exp2(8'h88, 8'h77);
        data0 = 16'h7788;
        s0    = n_starts;
        trig0 = 1'b1;
        @(negedge clk);
        trig0 = 1'b0;
        wait_starts(s0 + 2, 200);
        @(negedge clk);
        check("t5_in_wait", busy0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_outputs", {start0, txd0, busy0, done0, ovr0}, '0);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_no_restart", n_starts - s0, 2);
        check("t5_busy_low", busy0, 1'b0);
        check("t5_overrun_cleared", ovr0, 1'b0);

        // 6: 24-bit word (checksum byte appended when enabled)
        exp3(8'hF0, 8'h02, 8'h01);
        data2 = 24'h0102F0;
        base  = n_done[2];
        trig2 = 1'b1;
        wait_done(2, base, 300);
        repeat (3) @(negedge clk);
        check("t6_done_once", n_done[2] - base, 1);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_busy_low", busy2, 1'b0);
        trig2 = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
